// File: rtl/skip_adder_pkg.sv
// Shared types and sizing helpers for the sequential carry-skip adder.
package skip_adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sas_state_t;

  // Number of slice passes needed to cover the full operand width.
  function automatic int unsigned calc_nsl(input int unsigned width, input int unsigned slice);
    return width / slice;
  endfunction

  // Slice counter width; never narrower than one bit.
  function automatic int unsigned calc_cnt_w(input int unsigned nsl);
    return (nsl > 1) ? $clog2(nsl) : 1;
  endfunction

endpackage

// File: rtl/carry_skip_slice.sv
// Narrow carry-skip adder slice: ripple chain with a group-propagate bypass.
module carry_skip_slice #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cin_i,
  output logic [Width-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_o
);

  logic [Width:0]   c;
  logic [Width-1:0] p;
  logic             grp_p;

  // Ripple chain; c[i] is the carry into bit i.
  always_comb begin
    c     = '0;
    c[0]  = cin_i;
    p     = a_i ^ b_i;
    sum_o = '0;
    for (int i = 0; i < Width; i++) begin
      sum_o[i] = p[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (p[i] & c[i]);
    end
  end

  // When every bit propagates, the incoming carry skips straight to the output.
  always_comb begin
    grp_p   = &p;
    cout_o  = grp_p ? cin_i : c[Width];
    c_msb_o = c[Width-1];
  end

endmodule

// File: rtl/skip_adder_sequencer.sv
// Multi-cycle wide adder: one carry-skip slice reused LSB-first over Width/Slice cycles,
// with valid/ready handshakes on both sides.
module skip_adder_sequencer #(
  parameter int unsigned Width = 32,
  parameter int unsigned Slice = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  import skip_adder_pkg::*;

  localparam int unsigned Nsl  = calc_nsl(Width, Slice);
  localparam int unsigned CntW = calc_cnt_w(Nsl);

  if ((Width % Slice) != 0) begin : g_bad_width
    $error("skip_adder_sequencer: Width must be a multiple of Slice");
  end

  sas_state_t       state_q, state_d;
  logic [Width-1:0] a_sh_q, a_sh_d;
  logic [Width-1:0] b_sh_q, b_sh_d;
  logic [Width-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [Slice-1:0]       s_sum;
  logic                   s_cout;
  logic                   s_c_msb;
  logic [Width+Slice-1:0] sum_ext;

  carry_skip_slice #(
    .Width (Slice)
  ) u_slice (
    .a_i     (a_sh_q[Slice-1:0]),
    .b_i     (b_sh_q[Slice-1:0]),
    .cin_i   (carry_q),
    .sum_o   (s_sum),
    .cout_o  (s_cout),
    .c_msb_o (s_c_msb)
  );

  // Slice result enters from the top so the LSB slice ends up at bit 0 after Nsl passes.
  assign sum_ext = {s_sum, sum_q};

  // Next-state: FSM, operand/result shifting, carry and counter.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d   = sum_ext[Width+Slice-1:Slice];
        a_sh_d  = a_sh_q >> Slice;
        b_sh_d  = b_sh_q >> Slice;
        carry_d = s_cout;
        if (cnt_q == CntW'(Nsl - 1)) begin
          cout_d  = s_cout;
          ovf_d   = s_c_msb ^ s_cout;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

endmodule
